// File: rtl/pipe_mem_stage.sv
// pipe_mem_stage
//   Execute -> memory pipeline register with a valid/ready handshake, an
//   optional 1-entry skid buffer, a synchronous flush and a saturating
//   stall-cycle counter. Back-pressure from the memory stage never drops an
//   entry. With the skid buffer present the stage accepts a new entry every
//   cycle, and in_ready has no combinational path from out_ready.
//
// Ports
//   clk, reset (async, active-low), flush (sync kill of held + incoming)
//   in_valid/in_ready                execute-side handshake
//   *_e                              execute-stage payload fields
//   out_valid/out_ready              memory-side handshake
//   *_m                              held payload; write enables gated by out_valid
//   stall_cnt                        cycles with out_valid & !out_ready (saturating)
module pipe_mem_stage #(
  parameter int XLEN    = 32,
  parameter int RD_W    = 5,
  parameter int SRC_W   = 2,
  parameter int CNT_W   = 16,
  parameter int SKID_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             reg_write_e,
  input  logic [SRC_W-1:0] result_src_e,
  input  logic             mem_write_e,
  input  logic [XLEN-1:0]  alu_result_e,
  input  logic [XLEN-1:0]  wdata_e,
  input  logic [RD_W-1:0]  rd_e,
  input  logic [XLEN-1:0]  pc_plus4_e,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             reg_write_m,
  output logic             mem_write_m,
  output logic [SRC_W-1:0] result_src_m,
  output logic [XLEN-1:0]  alu_result_m,
  output logic [XLEN-1:0]  wdata_m,
  output logic [RD_W-1:0]  rd_m,
  output logic [XLEN-1:0]  pc_plus4_m,
  output logic [CNT_W-1:0] stall_cnt
);

  // Payload packed as {reg_write, mem_write, result_src, alu, wdata, rd, pc+4}
  localparam int PW = 2 + SRC_W + 3 * XLEN + RD_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PW-1:0]    in_pl;
  logic             main_valid_reg, main_valid_next;
  logic [PW-1:0]    main_pl_reg, main_pl_next;
  logic             skid_valid_reg, skid_valid_next;
  logic [PW-1:0]    skid_pl_reg, skid_pl_next;
  logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
  logic             in_fire, out_fire;
  logic             reg_write_h, mem_write_h;

  assign in_pl = {reg_write_e, mem_write_e, result_src_e, alu_result_e, wdata_e, rd_e, pc_plus4_e};

  generate
    if (SKID_EN != 0) begin : g_skid
      // Ready depends only on flops: the skid slot absorbs the one entry that
      // may arrive in the cycle the memory stage stalls.
      assign in_ready = !skid_valid_reg;
    end else begin : g_noskid
      assign in_ready = !main_valid_reg | out_ready;
    end
  endgenerate

  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_valid_reg & out_ready;

  always_comb begin
    main_valid_next = main_valid_reg;
    main_pl_next    = main_pl_reg;
    skid_valid_next = skid_valid_reg;
    skid_pl_next    = skid_pl_reg;
    stall_cnt_next  = stall_cnt_reg;

    if (main_valid_reg && !out_ready && (stall_cnt_reg != CNT_MAX)) begin
      stall_cnt_next = stall_cnt_reg + 1'b1;
    end

    if (flush) begin
      // Payload flops keep stale data; only the valid bits matter.
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else if (!main_valid_reg || out_fire) begin
      if (skid_valid_reg) begin
        // Oldest entry (skid) moves forward first to preserve order.
        main_valid_next = 1'b1;
        main_pl_next    = skid_pl_reg;
        skid_valid_next = in_fire;
        if (in_fire) begin
          skid_pl_next = in_pl;
        end
      end else begin
        main_valid_next = in_fire;
        if (in_fire) begin
          main_pl_next = in_pl;
        end
      end
    end else if ((SKID_EN != 0) && in_fire) begin
      // Main is stalled: park the new entry, main stays untouched.
      skid_valid_next = 1'b1;
      skid_pl_next    = in_pl;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_valid_reg <= 1'b0;
      main_pl_reg    <= '0;
      skid_valid_reg <= 1'b0;
      skid_pl_reg    <= '0;
      stall_cnt_reg  <= '0;
    end else begin
      main_valid_reg <= main_valid_next;
      main_pl_reg    <= main_pl_next;
      skid_valid_reg <= skid_valid_next;
      skid_pl_reg    <= skid_pl_next;
      stall_cnt_reg  <= stall_cnt_next;
    end
  end

  assign {reg_write_h, mem_write_h, result_src_m, alu_result_m, wdata_m, rd_m, pc_plus4_m} = main_pl_reg;

  // Side-effect enables never leak out of bubbles or flushed slots.
  assign out_valid   = main_valid_reg;
  assign reg_write_m = reg_write_h & main_valid_reg;
  assign mem_write_m = mem_write_h & main_valid_reg;
  assign stall_cnt   = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Testbench for pipe_mem_stage: default build (d0), CNT_W=4 build (d1) sharing
// d0's stimulus, and a SKID_EN=0 build (d2) driven by random valid/ready.
module tb_pipe_mem_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush;
  logic        in_valid, out_ready, reg_write_e, mem_write_e;
  logic [1:0]  result_src_e;
  logic [31:0] alu_result_e, wdata_e, pc_plus4_e;
  logic [4:0]  rd_e;

  // d0 outputs
  logic        in_ready, out_valid, reg_write_m, mem_write_m;
  logic [1:0]  result_src_m;
  logic [31:0] alu_result_m, wdata_m, pc_plus4_m;
  logic [4:0]  rd_m;
  logic [15:0] stall_cnt;

  // d1 outputs (CNT_W=4)
  logic        in_ready_s, out_valid_s, reg_write_m_s, mem_write_m_s;
  logic [1:0]  result_src_m_s;
  logic [31:0] alu_result_m_s, wdata_m_s, pc_plus4_m_s;
  logic [4:0]  rd_m_s;
  logic [3:0]  stall_cnt_s;

  // d2 (SKID_EN=0) own handshake and outputs
  logic        in_valid_n, out_ready_n;
  logic [31:0] alu_result_e_n;
  logic        in_ready_n, out_valid_n, reg_write_m_n, mem_write_m_n;
  logic [1:0]  result_src_m_n;
  logic [31:0] alu_result_m_n, wdata_m_n, pc_plus4_m_n;
  logic [4:0]  rd_m_n;
  logic [15:0] stall_cnt_n;

  int checks = 0;
  int failures = 0;

  pipe_mem_stage d0 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .reg_write_e(reg_write_e), .result_src_e(result_src_e), .mem_write_e(mem_write_e),
    .alu_result_e(alu_result_e), .wdata_e(wdata_e), .rd_e(rd_e), .pc_plus4_e(pc_plus4_e),
    .out_valid(out_valid), .out_ready(out_ready), .reg_write_m(reg_write_m),
    .mem_write_m(mem_write_m), .result_src_m(result_src_m), .alu_result_m(alu_result_m),
    .wdata_m(wdata_m), .rd_m(rd_m), .pc_plus4_m(pc_plus4_m), .stall_cnt(stall_cnt)
  );

  pipe_mem_stage #(.CNT_W(4)) d1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_s),
    .reg_write_e(reg_write_e), .result_src_e(result_src_e), .mem_write_e(mem_write_e),
    .alu_result_e(alu_result_e), .wdata_e(wdata_e), .rd_e(rd_e), .pc_plus4_e(pc_plus4_e),
    .out_valid(out_valid_s), .out_ready(out_ready), .reg_write_m(reg_write_m_s),
    .mem_write_m(mem_write_m_s), .result_src_m(result_src_m_s), .alu_result_m(alu_result_m_s),
    .wdata_m(wdata_m_s), .rd_m(rd_m_s), .pc_plus4_m(pc_plus4_m_s), .stall_cnt(stall_cnt_s)
  );

  pipe_mem_stage #(.SKID_EN(0)) d2 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid_n), .in_ready(in_ready_n),
    .reg_write_e(reg_write_e), .result_src_e(result_src_e), .mem_write_e(mem_write_e),
    .alu_result_e(alu_result_e_n), .wdata_e(wdata_e), .rd_e(rd_e), .pc_plus4_e(pc_plus4_e),
    .out_valid(out_valid_n), .out_ready(out_ready_n), .reg_write_m(reg_write_m_n),
    .mem_write_m(mem_write_m_n), .result_src_m(result_src_m_n), .alu_result_m(alu_result_m_n),
    .wdata_m(wdata_m_n), .rd_m(rd_m_n), .pc_plus4_m(pc_plus4_m_n), .stall_cnt(stall_cnt_n)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] sb_q[$];
    logic [31:0] exp_v;

    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    reg_write_e = 1'b0; mem_write_e = 1'b0; result_src_e = 2'd0;
    alu_result_e = 32'd0; wdata_e = 32'd0; pc_plus4_e = 32'd0; rd_e = 5'd0;
    in_valid_n = 1'b0; out_ready_n = 1'b0; alu_result_e_n = 32'd0;

    // 1: reset
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    check("rst_alu", 64'(alu_result_m), 64'd0);
    check("rst_rd", 64'(rd_m), 64'd0);
    check("rst_reg_write", 64'(reg_write_m), 64'd0);
    $display("T1 reset: out_valid=%0d in_ready=%0d stall_cnt=%0d", out_valid, in_ready, stall_cnt);

    // 2: stream rd=1..8, no bubbles, 1-cycle latency
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1;
      rd_e = 5'(k);
      alu_result_e = 32'(k * 16);
      tick();
      check("stream_valid", 64'(out_valid), 64'd1);
      check("stream_rd", 64'(rd_m), 64'(k));
      check("stream_ready", 64'(in_ready), 64'd1);
      $display("T2 stream: rd_m=%0d out_valid=%0d", rd_m, out_valid);
    end
    in_valid = 1'b0;
    tick();
    check("stream_drain", 64'(out_valid), 64'd0);
    check("stream_no_stall", 64'(stall_cnt), 64'd0);

    // 3: A held under back-pressure, B parked in skid
    out_ready = 1'b0;
    in_valid = 1'b1; alu_result_e = 32'h100; rd_e = 5'd10;
    tick();
    check("skid_A_loaded", 64'(alu_result_m), 64'h100);
    alu_result_e = 32'h200; rd_e = 5'd11;
    tick();
    in_valid = 1'b0;
    check("skid_in_ready", 64'(in_ready), 64'd0);
    check("skid_A_stable1", 64'(alu_result_m), 64'h100);
    repeat (2) tick();
    check("skid_stall_cnt", 64'(stall_cnt), 64'd3);
    check("skid_A_stable3", 64'(alu_result_m), 64'h100);
    check("skid_A_rd", 64'(rd_m), 64'd10);
    out_ready = 1'b1;
    #1;
    check("skid_A_out", 64'(out_valid), 64'd1);
    tick();
    check("skid_B_alu", 64'(alu_result_m), 64'h200);
    check("skid_B_rd", 64'(rd_m), 64'd11);
    check("skid_B_in_ready", 64'(in_ready), 64'd1);
    tick();
    check("skid_empty", 64'(out_valid), 64'd0);
    $display("T3 skid: stall_cnt=%0d", stall_cnt);

    // 4: flush with main + skid full and a store offered
    out_ready = 1'b0;
    in_valid = 1'b1; reg_write_e = 1'b1; mem_write_e = 1'b1;
    alu_result_e = 32'h300; rd_e = 5'd12;
    tick();
    check("fl_mem_write_pre", 64'(mem_write_m), 64'd1);
    check("fl_reg_write_pre", 64'(reg_write_m), 64'd1);
    alu_result_e = 32'h400; rd_e = 5'd13;
    tick();
    check("fl_skid_full", 64'(in_ready), 64'd0);
    flush = 1'b1; rd_e = 5'd20;
    tick();
    flush = 1'b0; in_valid = 1'b0; reg_write_e = 1'b0; mem_write_e = 1'b0;
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_mem_write", 64'(mem_write_m), 64'd0);
    check("fl_reg_write", 64'(reg_write_m), 64'd0);
    check("fl_in_ready", 64'(in_ready), 64'd1);
    check("fl_stall_kept", 64'(stall_cnt), 64'd5);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("fl_no_emit", 64'(out_valid), 64'd0);
    end
    $display("T4 flush: out_valid=%0d stall_cnt=%0d", out_valid, stall_cnt);

    // 5: saturation of the 4-bit counter
    out_ready = 1'b0;
    in_valid = 1'b1; rd_e = 5'd21;
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    check("sat_cnt4", 64'(stall_cnt_s), 64'd15);
    check("sat_cnt16", 64'(stall_cnt), 64'd25);
    repeat (2) tick();
    check("sat_cnt4_hold", 64'(stall_cnt_s), 64'd15);
    check("sat_cnt16_more", 64'(stall_cnt), 64'd27);
    check("sat_rd_stable", 64'(rd_m_s), 64'd21);
    out_ready = 1'b1;
    tick();
    check("sat_drained", 64'(out_valid_s), 64'd0);
    $display("T5 saturate: stall_cnt_s=%0d stall_cnt=%0d", stall_cnt_s, stall_cnt);

    // 6: no-skid build, random handshake, scoreboard
    out_ready = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      in_valid_n = 1'($urandom_range(0, 1));
      out_ready_n = 1'($urandom_range(0, 1));
      alu_result_e_n = $urandom;
      #1;
      check("ns_in_ready", 64'(in_ready_n), 64'(!out_valid_n || out_ready_n));
      if (out_valid_n && out_ready_n) begin
        if (sb_q.size() == 0) begin
          check("ns_underflow", 64'd1, 64'(sb_q.size()));
        end else begin
          exp_v = sb_q.pop_front();
          check("ns_data", 64'(alu_result_m_n), 64'(exp_v));
        end
      end
      if (in_valid_n && in_ready_n) sb_q.push_back(alu_result_e_n);
      tick();
    end
    in_valid_n = 1'b0; out_ready_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (out_valid_n && sb_q.size() != 0) begin
        exp_v = sb_q.pop_front();
        check("ns_drain_data", 64'(alu_result_m_n), 64'(exp_v));
      end
      tick();
    end
    check("ns_no_loss", 64'(sb_q.size()), 64'd0);
    check("ns_empty", 64'(out_valid_n), 64'd0);
    $display("T6 noskid: pending=%0d out_valid=%0d", sb_q.size(), out_valid_n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
